// File: rtl/door_input_conditioner.sv
// Front end for the door-control FSM: synchronises and debounces the four raw field
// inputs, stretches presence with a hold-open timer and flags a sticky dual-limit fault.
module door_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sen_raw,
  input  logic se_raw,
  input  logic la_raw,
  input  logic lc_raw,
  input  logic fault_clr,
  output logic sen_clean,
  output logic sen_hold,
  output logic se_clean,
  output logic la_clean,
  output logic lc_clean,
  output logic sen_rise,
  output logic limit_fault
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  // Channel order: 0 presence, 1 safety, 2 open limit, 3 closed limit.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] clean_nxt;

  assign raw = {lc_raw, la_raw, se_raw, sen_raw};

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   stable_q;
    logic                   stable_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw[g]};
      stable_d = stable_q;
      cnt_d    = '0;
      // The count only advances while the synchronised level disagrees with the
      // stable level, so any agreeing sample restarts the qualification window.
      if (sync_out != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync_out;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= '0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (ena) begin
        sync_q   <= sync_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign clean[g]     = stable_q;
    assign clean_nxt[g] = stable_d;
  end

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              rise_q;
  logic              rise_d;
  logic              fault_q;
  logic              fault_d;

  always_comb begin
    hold_d = hold_q;
    if (clean[0]) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
    rise_d  = clean_nxt[0] & ~clean[0];
    // Set term is OR-ed last so a persisting fault survives a simultaneous clear.
    fault_d = (fault_q & ~fault_clr) | (clean[2] & clean[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      rise_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (ena) begin
      hold_q  <= hold_d;
      rise_q  <= rise_d;
      fault_q <= fault_d;
    end else begin
      rise_q  <= 1'b0;
    end
  end

  assign sen_clean   = clean[0];
  assign sen_hold    = clean[0] | (hold_q != '0);
  assign se_clean    = clean[1];
  assign la_clean    = clean[2];
  assign lc_clean    = clean[3];
  assign sen_rise    = rise_q;
  assign limit_fault = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Self-checking bench for door_input_conditioner: directed scenarios plus random
// stimulus, all compared against a run-length behavioural model of the input rules.
module tb_door_input_conditioner;

  localparam int S = 2;
  localparam int D = 16;
  localparam int H = 64;

  logic clk;
  logic rst_n;
  logic ena;
  logic sen_raw;
  logic se_raw;
  logic la_raw;
  logic lc_raw;
  logic fault_clr;
  logic sen_clean;
  logic sen_hold;
  logic se_clean;
  logic la_clean;
  logic lc_clean;
  logic sen_rise;
  logic limit_fault;

  logic [6:0] dut_vec;

  int n_cmp;
  int n_bad;

  door_input_conditioner #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .sen_raw(sen_raw),
    .se_raw(se_raw),
    .la_raw(la_raw),
    .lc_raw(lc_raw),
    .fault_clr(fault_clr),
    .sen_clean(sen_clean),
    .sen_hold(sen_hold),
    .se_clean(se_clean),
    .la_clean(la_clean),
    .lc_clean(lc_clean),
    .sen_rise(sen_rise),
    .limit_fault(limit_fault)
  );

  assign dut_vec = {sen_clean, sen_hold, se_clean, la_clean, lc_clean, sen_rise, limit_fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer S enabled edges later; a level is
  // accepted once D consecutive delayed samples agree and differ from the clean level.
  bit [3:0] m_pipe[$];
  bit [3:0] m_clean;
  bit       m_last[4];
  int       m_run[4];
  int       m_n;
  bit       m_rise;
  bit       m_fault;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < S; i++) m_pipe.push_back(4'b0);
    m_clean = 4'b0;
    for (int c = 0; c < 4; c++) begin
      m_last[c] = 1'b0;
      m_run[c]  = 0;
    end
    m_n     = H;
    m_rise  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    bit [3:0] r;
    bit [3:0] seen;
    bit [3:0] old;
    if (!ena) begin
      m_rise = 1'b0;
      return;
    end
    r    = {lc_raw, la_raw, se_raw, sen_raw};
    old  = m_clean;
    seen = m_pipe.pop_front();
    m_pipe.push_back(r);
    for (int c = 0; c < 4; c++) begin
      if (seen[c] == m_last[c]) m_run[c]++;
      else m_run[c] = 1;
      m_last[c] = seen[c];
      if (m_run[c] >= D && seen[c] != m_clean[c]) m_clean[c] = seen[c];
    end
    if (old[0]) m_n = 0;
    else if (m_n < H) m_n++;
    m_rise = m_clean[0] & ~old[0];
    if (old[2] && old[3]) m_fault = 1'b1;
    else if (fault_clr) m_fault = 1'b0;
  endtask

  function automatic logic [6:0] model_vec();
    return {m_clean[0], (m_clean[0] || (m_n < H)), m_clean[1], m_clean[2], m_clean[3],
            m_rise, m_fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; fault_clr = 1'b0;
    sen_raw = 1'b0; se_raw = 1'b0; la_raw = 1'b0; lc_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_bad++; $display("FAIL reset_hold: got %b want %b", dut_vec, 7'b0);
    end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", dut_vec, 7'b0);
    end
  endtask

  task automatic test_sen_latency();
    int edges;
    sen_raw = 1'b1;
    edges = 0;
    while (sen_clean !== 1'b1 && edges < 40) begin
      tick(); edges++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL sen_step_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (edges != S + D) begin
      n_bad++; $display("FAIL sen_latency: got %0d edges want %0d", edges, S + D);
    end
    n_cmp++;
    if (sen_rise !== 1'b1 || sen_hold !== 1'b1) begin
      n_bad++; $display("FAIL sen_rise_hold: got rise=%b hold=%b want 1 1", sen_rise, sen_hold);
    end
    tick();
    n_cmp++;
    if (sen_rise !== 1'b0 || sen_clean !== 1'b1) begin
      n_bad++; $display("FAIL sen_rise_width: got rise=%b clean=%b want 0 1", sen_rise, sen_clean);
    end
  endtask

  task automatic test_glitch();
    bit saw_high;
    int rise_at;
    saw_high = 1'b0;
    la_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) la_raw = 1'b0;
      tick();
      saw_high |= la_clean;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL glitch_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (saw_high) begin
      n_bad++; $display("FAIL la_glitch: got la_clean high want it to stay 0");
    end
    rise_at = 0;
    la_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 17) la_raw = 1'b0;
      tick();
      if (la_clean === 1'b1) begin
        rise_at = k;
        break;
      end
    end
    n_cmp++;
    if (rise_at != S + D) begin
      n_bad++; $display("FAIL la_pulse_latency: got %0d edges want %0d", rise_at, S + D);
    end
    la_raw = 1'b0;
    repeat (40) begin
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL la_pulse_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (la_clean !== 1'b0) begin
      n_bad++; $display("FAIL la_release: got %b want 0", la_clean);
    end
  endtask

  task automatic test_hold();
    int edges;
    int held;
    bit gap;
    sen_raw = 1'b0;
    edges = 0;
    while (sen_clean !== 1'b0 && edges < 40) begin tick(); edges++; end
    held = 0;
    while (sen_hold === 1'b1 && sen_clean === 1'b0 && held < 200) begin
      held++;
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL hold_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (held != H) begin
      n_bad++; $display("FAIL hold_len: got %0d cycles want %0d", held, H);
    end
    sen_raw = 1'b1;
    edges = 0;
    while (sen_clean !== 1'b1 && edges < 40) begin tick(); edges++; end
    sen_raw = 1'b0;
    edges = 0;
    while (sen_clean !== 1'b0 && edges < 40) begin tick(); edges++; end
    gap = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 30) sen_raw = 1'b1;
      tick();
      gap |= ~sen_hold;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL represence_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (gap || sen_clean !== 1'b1) begin
      n_bad++; $display("FAIL hold_no_gap: got gap=%b clean=%b want 0 1", gap, sen_clean);
    end
    sen_raw = 1'b0;
  endtask

  task automatic test_fault();
    int edges;
    la_raw = 1'b1; lc_raw = 1'b1;
    edges = 0;
    while (limit_fault !== 1'b1 && edges < 60) begin tick(); edges++; end
    n_cmp++;
    if (edges != S + D + 1) begin
      n_bad++; $display("FAIL fault_set_latency: got %0d edges want %0d", edges, S + D + 1);
    end
    la_raw = 1'b0; lc_raw = 1'b0;
    repeat (40) begin
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL fault_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (limit_fault !== 1'b1 || la_clean !== 1'b0 || lc_clean !== 1'b0) begin
      n_bad++; $display("FAIL fault_sticky: got fault=%b la=%b lc=%b want 1 0 0",
                        limit_fault, la_clean, lc_clean);
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    n_cmp++;
    if (limit_fault !== 1'b0) begin
      n_bad++; $display("FAIL fault_clear: got %b want 0", limit_fault);
    end
    la_raw = 1'b1; lc_raw = 1'b1;
    edges = 0;
    while (limit_fault !== 1'b1 && edges < 60) begin tick(); edges++; end
    fault_clr = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (limit_fault !== 1'b1) begin
      n_bad++; $display("FAIL fault_set_wins: got %b want 1", limit_fault);
    end
    fault_clr = 1'b0; la_raw = 1'b0; lc_raw = 1'b0;
    repeat (40) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    n_cmp++;
    if (limit_fault !== 1'b0 || dut_vec !== model_vec()) begin
      n_bad++; $display("FAIL fault_clear2: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_ena_freeze();
    logic [6:0] snap;
    bit frozen_ok;
    int edges;
    se_raw = 1'b1;
    repeat (S + 8) tick();
    snap = dut_vec;
    ena = 1'b0;
    frozen_ok = 1'b1;
    repeat (20) begin
      tick();
      if (dut_vec !== snap) frozen_ok = 1'b0;
    end
    n_cmp++;
    if (!frozen_ok || se_clean !== 1'b0) begin
      n_bad++; $display("FAIL ena_freeze: got %b want %b (se_clean 0)", dut_vec, snap);
    end
    ena = 1'b1;
    edges = 0;
    while (se_clean !== 1'b1 && edges < 40) begin tick(); edges++; end
    n_cmp++;
    if (edges != D - 8) begin
      n_bad++; $display("FAIL ena_resume: got %0d edges want %0d", edges, D - 8);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    bit any_rise;
    sen_raw = 1'b1;
    edges = 0;
    while (sen_clean !== 1'b1 && edges < 40) begin tick(); edges++; end
    sen_raw = 1'b0;
    edges = 0;
    while (sen_clean !== 1'b0 && edges < 40) begin tick(); edges++; end
    repeat (10) tick();
    la_raw = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (sen_hold !== 1'b1 || dut_vec !== model_vec()) begin
      n_bad++; $display("FAIL pre_reset: got %b want %b", dut_vec, model_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", dut_vec, 7'b0);
    end
    model_reset();
    sen_raw = 1'b0; se_raw = 1'b0; la_raw = 1'b0; lc_raw = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    any_rise = 1'b0;
    repeat (30) begin
      tick();
      any_rise |= sen_rise;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL post_reset_model: got %b want %b", dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (any_rise) begin
      n_bad++; $display("FAIL no_rise_after_reset: got sen_rise pulse want none");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) sen_raw = ~sen_raw;
      if ($urandom_range(0, 19) == 0) se_raw  = ~se_raw;
      if ($urandom_range(0, 19) == 0) la_raw  = ~la_raw;
      if ($urandom_range(0, 19) == 0) lc_raw  = ~lc_raw;
      ena       = ($urandom_range(0, 9) != 0);
      fault_clr = ($urandom_range(0, 29) == 0);
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL random_%0d: got %b want %b", k, dut_vec, model_vec());
      end
    end
    ena = 1'b1; fault_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sen_latency();
    test_glitch();
    test_hold();
    test_fault();
    test_ena_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
